cluster_axi_isolate_ctrl: RTL and testbench
===========================================

Name: cluster_axi_isolate_ctrl

Overview:
Drain-and-isolate controller for one AXI port of the cluster crossbar, e.g. the external master port toward the SoC. It tracks outstanding reads and writes, caps them at a configurable limit, and on request stops new AW/AR without breaking an in-flight valid. It reports isolated once every transaction has completed, for power-down or address-map reconfiguration such as a cluster_id change. Handshake signals only; payloads bypass the block.

Parameters:
MAX_TXNS, 16, max outstanding transactions per direction (write, read); must be >= 1
CNT_W, $clog2(MAX_TXNS+1), outstanding-counter width (derived localparam)
WP_W, CNT_W+1, signed W-pending counter width (derived localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
isolate_req_i  in  1  level request to quiesce the port
isolated_o  out  1  port quiescent and gated
aw_valid_i  in  1  upstream AW valid
aw_ready_o  out  1  upstream AW ready
aw_valid_o  out  1  downstream AW valid
aw_ready_i  in  1  downstream AW ready
ar_valid_i  in  1  upstream AR valid
ar_ready_o  out  1  upstream AR ready
ar_valid_o  out  1  downstream AR valid
ar_ready_i  in  1  downstream AR ready
w_valid_i / w_ready_i / w_last_i  in  1 each  observed W handshake
b_valid_i / b_ready_i  in  1 each  observed B handshake
r_valid_i / r_ready_i / r_last_i  in  1 each  observed R handshake
wr_outstanding_o  out  CNT_W  AW accepted minus B completed
rd_outstanding_o  out  CNT_W  AR accepted minus R-last completed
err_o  out  1  sticky protocol error

Behaviour:
- Reset values: state RUN; all counters 0; isolated_o=0; err_o=0; hold flags 0.
- Handshake events: aw_hs = aw_valid_o & aw_ready_i; ar_hs likewise; b_hs = b_valid_i & b_ready_i; r_hs = r_valid_i & r_ready_i & r_last_i; wl_hs = w_valid_i & w_ready_i & w_last_i.
- Counters update at the edge:
  - wr_cnt += aw_hs - b_hs.
  - rd_cnt += ar_hs - r_hs.
  - w_pend (signed) += aw_hs - wl_hs. It may go negative because W may precede AW.
  - A simultaneous increment and decrement leaves the counter unchanged.
- Hold flags:
  - aw_hold <= aw_valid_o & ~aw_ready_i.
  - ar_hold likewise.
  - A held channel stays open until its handshake, regardless of state or limit, so valid is never retracted.
- Gate per channel: open_aw = aw_hold | (state==RUN & wr_cnt<MAX_TXNS). open_ar uses rd_cnt in the same way.
- Combinational pass-through, zero latency:
  - aw_valid_o = aw_valid_i & open_aw.
  - aw_ready_o = aw_ready_i & open_aw.
  - AR channel identical.
- FSM:
  - RUN -> DRAIN when isolate_req_i=1.
  - DRAIN -> RUN when isolate_req_i=0; there is no need to wait.
  - DRAIN -> ISOLATED when isolate_req_i=1, wr_cnt=0, rd_cnt=0, w_pend=0, no hold flag set, and no aw_hs/ar_hs/b_hs/r_hs/wl_hs this cycle.
  - ISOLATED -> RUN when isolate_req_i=0.
- isolated_o is registered and equals (state==ISOLATED): high from the edge entering ISOLATED, low from the edge leaving it.
- Minimum request-to-isolated latency with an idle port: 2 cycles (RUN->DRAIN, DRAIN->ISOLATED).
- err_o is set, never cleared except by reset, on any of:
  - b_hs with wr_cnt=0;
  - r_hs with rd_cnt=0;
  - aw_hs/ar_hs at a counter equal to MAX_TXNS (only possible via protocol misuse);
  - aw_hs or ar_hs while ISOLATED.
  On an error the counter saturates at 0 or MAX_TXNS and does not wrap.
- Reset mid-operation: all state is cleared. Upstream and downstream logic are reset in the same domain.

Decomposition:
- cluster_axi_isolate_pkg: state enum (RUN, DRAIN, ISOLATED), error-cause encoding.
- One sub-module, axi_txn_counter (inc/dec, saturate, underflow/overflow flags), instantiated twice plus a signed variant for w_pend.

Test Plan:
- Idle port, isolate_req_i rises at cycle 0 -> isolated_o=1 at cycle 2; aw_valid_i=1 then yields aw_valid_o=0 and aw_ready_o=0.
- 3 writes accepted, isolate_req_i=1 -> gate closes next cycle; isolated_o stays 0 until the third B handshake and last W beat, then rises one cycle later; wr_outstanding_o steps 3,2,1,0.
- aw_valid_o held with aw_ready_i=0 when the request arrives -> aw_valid_o stays 1 until aw_ready_i=1; wr_cnt becomes 1 and the gate then closes.
- MAX_TXNS=2, continuous AR with no R -> third AR stalled (ar_ready_o=0); one R-last frees it, and the AR handshake completes the next cycle.
- Same-cycle ar_hs and r_hs with rd_cnt=1 -> rd_cnt stays 1; B handshake with wr_cnt=0 -> err_o=1 sticky, wr_cnt stays 0.
- isolate_req_i dropped in DRAIN with 2 outstanding -> RUN next cycle, traffic passes again; rst_i mid-DRAIN -> counters 0, state RUN, isolated_o=0.

Source files
------------

// File: rtl/cluster_axi_isolate_pkg.sv
// Shared types for the cluster AXI drain-and-isolate controller.
package cluster_axi_isolate_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ISOLATED = 2'd2
    } iso_state_e;

    // One bit per protocol-error cause; any set bit makes the sticky error.
    typedef struct packed {
        logic wr_underflow;
        logic rd_underflow;
        logic wr_overflow;
        logic rd_overflow;
        logic addr_while_iso;
    } err_cause_t;

endpackage

// File: rtl/axi_txn_counter.sv
// Saturating up/down transaction counter; SIGNED selects a symmetric
// -MAX..MAX range instead of 0..MAX.
module axi_txn_counter #(
    parameter int unsigned W      = 5,
    parameter int unsigned MAX    = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o,
    output logic         full_o,
    output logic         ovf_o,
    output logic         unf_o
);

    localparam logic [W-1:0] HI_LIM = W'(MAX);
    localparam logic [W-1:0] LO_LIM = SIGNED ? W'(0 - int'(MAX)) : '0;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_hi;
    logic         at_lo;

    assign at_hi  = (cnt_q == HI_LIM);
    assign at_lo  = (cnt_q == LO_LIM);
    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign full_o = at_hi;
    assign ovf_o  = inc_i & at_hi;
    assign unf_o  = dec_i & at_lo;

    // Simultaneous inc/dec cancel; out-of-range steps hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !at_hi) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i && !at_lo) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cluster_axi_isolate_ctrl.sv
// Drain-and-isolate controller for one AXI port: limits outstanding AW/AR,
// gates new address phases on request and reports when the port is quiet.
module cluster_axi_isolate_ctrl
    import cluster_axi_isolate_pkg::*;
#(
    parameter  int unsigned MAX_TXNS = 16,
    localparam int unsigned CNT_W    = $clog2(MAX_TXNS + 1),
    localparam int unsigned WP_W     = CNT_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             isolate_req_i,
    output logic             isolated_o,
    input  logic             aw_valid_i,
    output logic             aw_ready_o,
    output logic             aw_valid_o,
    input  logic             aw_ready_i,
    input  logic             ar_valid_i,
    output logic             ar_ready_o,
    output logic             ar_valid_o,
    input  logic             ar_ready_i,
    input  logic             w_valid_i,
    input  logic             w_ready_i,
    input  logic             w_last_i,
    input  logic             b_valid_i,
    input  logic             b_ready_i,
    input  logic             r_valid_i,
    input  logic             r_ready_i,
    input  logic             r_last_i,
    output logic [CNT_W-1:0] wr_outstanding_o,
    output logic [CNT_W-1:0] rd_outstanding_o,
    output logic             err_o
);

    iso_state_e      state_q, state_d;
    logic            aw_hold_q, aw_hold_d;
    logic            ar_hold_q, ar_hold_d;
    logic            isolated_q, isolated_d;
    logic            err_q, err_d;

    logic            open_aw, open_ar;
    logic            aw_hs, ar_hs, b_hs, r_hs, wl_hs;
    logic            wr_zero, wr_full, wr_ovf, wr_unf;
    logic            rd_zero, rd_full, rd_ovf, rd_unf;
    logic [WP_W-1:0] wp_cnt;
    logic [3:0]      wp_flags_unused;
    logic            quiet;
    err_cause_t      cause;

    // A held address phase stays open so an asserted valid is never dropped.
    assign open_aw = aw_hold_q | ((state_q == ST_RUN) & ~wr_full);
    assign open_ar = ar_hold_q | ((state_q == ST_RUN) & ~rd_full);

    assign aw_valid_o = aw_valid_i & open_aw;
    assign aw_ready_o = aw_ready_i & open_aw;
    assign ar_valid_o = ar_valid_i & open_ar;
    assign ar_ready_o = ar_ready_i & open_ar;

    assign aw_hs = aw_valid_o & aw_ready_i;
    assign ar_hs = ar_valid_o & ar_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;
    assign r_hs  = r_valid_i & r_ready_i & r_last_i;
    assign wl_hs = w_valid_i & w_ready_i & w_last_i;

    axi_txn_counter #(.W(CNT_W), .MAX(MAX_TXNS), .SIGNED(1'b0)) u_wr_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (aw_hs),
        .dec_i (b_hs),
        .cnt_o (wr_outstanding_o),
        .zero_o(wr_zero),
        .full_o(wr_full),
        .ovf_o (wr_ovf),
        .unf_o (wr_unf)
    );

    axi_txn_counter #(.W(CNT_W), .MAX(MAX_TXNS), .SIGNED(1'b0)) u_rd_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (ar_hs),
        .dec_i (r_hs),
        .cnt_o (rd_outstanding_o),
        .zero_o(rd_zero),
        .full_o(rd_full),
        .ovf_o (rd_ovf),
        .unf_o (rd_unf)
    );

    // W bursts may lead their AW, so pending write data is tracked signed.
    axi_txn_counter #(.W(WP_W), .MAX(MAX_TXNS), .SIGNED(1'b1)) u_wp_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (aw_hs),
        .dec_i (wl_hs),
        .cnt_o (wp_cnt),
        .zero_o(wp_flags_unused[0]),
        .full_o(wp_flags_unused[1]),
        .ovf_o (wp_flags_unused[2]),
        .unf_o (wp_flags_unused[3])
    );

    always_comb begin
        state_d    = state_q;
        aw_hold_d  = aw_valid_o & ~aw_ready_i;
        ar_hold_d  = ar_valid_o & ~ar_ready_i;
        quiet      = wr_zero & rd_zero & (wp_cnt == '0) & ~aw_hold_q & ~ar_hold_q
                   & ~(aw_hs | ar_hs | b_hs | r_hs | wl_hs);

        cause                = '0;
        cause.wr_underflow   = wr_unf;
        cause.rd_underflow   = rd_unf;
        cause.wr_overflow    = wr_ovf;
        cause.rd_overflow    = rd_ovf;
        cause.addr_while_iso = (aw_hs | ar_hs) & (state_q == ST_ISOLATED);
        err_d                = err_q | (|cause);

        unique case (state_q)
            ST_RUN: begin
                if (isolate_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!isolate_req_i) state_d = ST_RUN;
                else if (quiet)     state_d = ST_ISOLATED;
            end
            ST_ISOLATED: begin
                if (!isolate_req_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        isolated_d = (state_d == ST_ISOLATED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            aw_hold_q  <= 1'b0;
            ar_hold_q  <= 1'b0;
            isolated_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_hold_q  <= aw_hold_d;
            ar_hold_q  <= ar_hold_d;
            isolated_q <= isolated_d;
            err_q      <= err_d;
        end
    end

    assign isolated_o = isolated_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_cluster_axi_isolate_ctrl.sv
// Bench for cluster_axi_isolate_ctrl: directed scenarios plus random traffic,
// compared every cycle against a transaction-count reference model.
module tb_cluster_axi_isolate_ctrl;

    localparam int unsigned MAXT = 2;
    localparam int unsigned CW   = $clog2(MAXT + 1);
    localparam int M_RUN = 0, M_DRAIN = 1, M_ISO = 2;

    logic clk = 1'b0;
    logic rst_i, isolate_req_i, isolated_o;
    logic aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
    logic ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
    logic w_valid_i, w_ready_i, w_last_i, b_valid_i, b_ready_i;
    logic r_valid_i, r_ready_i, r_last_i, err_o;
    logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain transaction counts and a port mode.
    int m_wr = 0, m_rd = 0, m_wp = 0, m_mode = M_RUN;
    bit m_awh = 1'b0, m_arh = 1'b0, m_err = 1'b0;

    always #5 clk = ~clk;

    cluster_axi_isolate_ctrl #(.MAX_TXNS(MAXT)) dut (
        .clk_i(clk), .rst_i(rst_i), .isolate_req_i(isolate_req_i), .isolated_o(isolated_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
        .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
        .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
        .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic set_idle();
        aw_valid_i = 0; aw_ready_i = 0; ar_valid_i = 0; ar_ready_i = 0;
        w_valid_i = 0; w_ready_i = 0; w_last_i = 0;
        b_valid_i = 0; b_ready_i = 0; r_valid_i = 0; r_ready_i = 0; r_last_i = 0;
    endtask

    // Check all outputs against the model, then advance the model by one edge.
    task automatic step();
        bit oaw, oar, e_awv, e_arv, awh, arh, bh, rh, wlh, quiet;
        int n_mode;
        #1;
        oaw   = m_awh || (m_mode == M_RUN && m_wr < int'(MAXT));
        oar   = m_arh || (m_mode == M_RUN && m_rd < int'(MAXT));
        e_awv = aw_valid_i && oaw;
        e_arv = ar_valid_i && oar;
        chk("aw_valid_o", 32'(aw_valid_o), 32'(e_awv));
        chk("aw_ready_o", 32'(aw_ready_o), 32'(aw_ready_i && oaw));
        chk("ar_valid_o", 32'(ar_valid_o), 32'(e_arv));
        chk("ar_ready_o", 32'(ar_ready_o), 32'(ar_ready_i && oar));
        chk("wr_outstanding", 32'(wr_outstanding_o), 32'(m_wr));
        chk("rd_outstanding", 32'(rd_outstanding_o), 32'(m_rd));
        chk("isolated_o", 32'(isolated_o), 32'(m_mode == M_ISO));
        chk("err_o", 32'(err_o), 32'(m_err));

        awh = e_awv && aw_ready_i;
        arh = e_arv && ar_ready_i;
        bh  = b_valid_i && b_ready_i;
        rh  = r_valid_i && r_ready_i && r_last_i;
        wlh = w_valid_i && w_ready_i && w_last_i;
        quiet = m_wr == 0 && m_rd == 0 && m_wp == 0 && !m_awh && !m_arh
                && !(awh || arh || bh || rh || wlh);
        n_mode = m_mode;
        if (m_mode == M_RUN && isolate_req_i) n_mode = M_DRAIN;
        else if (m_mode == M_DRAIN && !isolate_req_i) n_mode = M_RUN;
        else if (m_mode == M_DRAIN && quiet) n_mode = M_ISO;
        else if (m_mode == M_ISO && !isolate_req_i) n_mode = M_RUN;
        @(posedge clk);
        if (rst_i) begin
            m_wr = 0; m_rd = 0; m_wp = 0; m_mode = M_RUN;
            m_awh = 0; m_arh = 0; m_err = 0;
        end else begin
            m_err = m_err || (bh && m_wr == 0) || (rh && m_rd == 0)
                    || (awh && m_wr == int'(MAXT)) || (arh && m_rd == int'(MAXT))
                    || ((awh || arh) && m_mode == M_ISO);
            m_wr   = clamp(m_wr + int'(awh) - int'(bh), 0, int'(MAXT));
            m_rd   = clamp(m_rd + int'(arh) - int'(rh), 0, int'(MAXT));
            m_wp   = clamp(m_wp + int'(awh) - int'(wlh), -int'(MAXT), int'(MAXT));
            m_awh  = e_awv && !aw_ready_i;
            m_arh  = e_arv && !ar_ready_i;
            m_mode = n_mode;
        end
        @(negedge clk);
    endtask

    task automatic rand_inputs(input bit req);
        isolate_req_i = req;
        aw_valid_i = m_awh ? 1'b1 : ($urandom_range(0, 2) == 0);
        aw_ready_i = 1'($urandom_range(0, 1));
        ar_valid_i = m_arh ? 1'b1 : ($urandom_range(0, 2) == 0);
        ar_ready_i = 1'($urandom_range(0, 1));
        w_valid_i  = 1'($urandom_range(0, 1));
        w_ready_i  = 1'($urandom_range(0, 1));
        w_last_i   = (m_wp > 0) && ($urandom_range(0, 1) == 1);
        b_valid_i  = (m_wr > 0) && ($urandom_range(0, 1) == 1);
        b_ready_i  = 1'($urandom_range(0, 1));
        r_valid_i  = (m_rd > 0) && ($urandom_range(0, 1) == 1);
        r_ready_i  = 1'($urandom_range(0, 1));
        r_last_i   = 1'($urandom_range(0, 1));
    endtask

    // Complete everything outstanding; a negative W count is repaid with an AW.
    task automatic flush(input bit req);
        for (int k = 0; k < 40; k++) begin
            if (m_wr == 0 && m_rd == 0 && m_wp == 0 && !m_awh && !m_arh) break;
            set_idle();
            isolate_req_i = req;
            aw_valid_i = m_awh || (m_wp < 0); aw_ready_i = 1;
            ar_valid_i = m_arh; ar_ready_i = 1;
            b_valid_i = (m_wr > 0); b_ready_i = 1;
            r_valid_i = (m_rd > 0); r_ready_i = 1; r_last_i = 1;
            w_valid_i = (m_wp > 0); w_ready_i = 1; w_last_i = 1;
            step();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_i = 1; isolate_req_i = 0;
        @(negedge clk);
        step(); step();
        rst_i = 0;
        #1 chk("rst_wr", 32'(wr_outstanding_o), 0);
        chk("rst_iso", 32'(isolated_o), 0);

        // Idle port: isolated two edges after the request.
        isolate_req_i = 1;
        step();
        #1 chk("iso_lat1", 32'(isolated_o), 0);
        step();
        #1 chk("iso_lat2", 32'(isolated_o), 1);
        aw_valid_i = 1; aw_ready_i = 1;
        #1 chk("iso_aw_valid", 32'(aw_valid_o), 0);
        chk("iso_aw_ready", 32'(aw_ready_o), 0);
        step();
        isolate_req_i = 0; set_idle();
        step();

        repeat (150) begin rand_inputs(1'b0); step(); end
        repeat (4) begin
            repeat (40) begin rand_inputs($urandom_range(0, 15) != 0); step(); end
            repeat (20) begin rand_inputs(1'b0); step(); end
        end
        flush(1'b0);
        isolate_req_i = 0; step();

        // Held AW must stay valid through the request until its handshake.
        aw_valid_i = 1; aw_ready_i = 0;
        step();
        isolate_req_i = 1;
        step();
        #1 chk("hold_valid", 32'(aw_valid_o), 1);
        step();
        aw_ready_i = 1;
        step();
        aw_ready_i = 0;
        #1 chk("hold_closed", 32'(aw_valid_o), 0);
        chk("hold_wr1", 32'(wr_outstanding_o), 1);
        step();
        flush(1'b1);
        step();
        #1 chk("hold_iso", 32'(isolated_o), 1);
        isolate_req_i = 0; step();

        // W beat ahead of its AW blocks isolation until the AW arrives.
        w_valid_i = 1; w_ready_i = 1; w_last_i = 1;
        step();
        set_idle(); isolate_req_i = 1;
        step(); step(); step();
        #1 chk("wfirst_no_iso", 32'(isolated_o), 0);
        isolate_req_i = 0; step();
        flush(1'b0);

        // Read limit: third AR stalls until an R-last frees a slot.
        ar_valid_i = 1; ar_ready_i = 1;
        step(); step();
        #1 chk("lim_stall", 32'(ar_ready_o), 0);
        chk("lim_rd2", 32'(rd_outstanding_o), 2);
        r_valid_i = 1; r_ready_i = 1; r_last_i = 1;
        step();
        r_valid_i = 0;
        #1 chk("lim_free", 32'(ar_ready_o), 1);
        step();
        #1 chk("lim_rd_again", 32'(rd_outstanding_o), 2);
        ar_valid_i = 0; r_valid_i = 1;
        step();
        ar_valid_i = 1;
        step();
        #1 chk("same_cycle_rd1", 32'(rd_outstanding_o), 1);
        flush(1'b0);

        // B with nothing outstanding: sticky error, counter stays at zero.
        b_valid_i = 1; b_ready_i = 1;
        step();
        b_valid_i = 0;
        #1 chk("err_set", 32'(err_o), 1);
        chk("err_wr0", 32'(wr_outstanding_o), 0);
        step(); step();
        #1 chk("err_sticky", 32'(err_o), 1);

        // Drop the request while draining, then reset mid-drain.
        aw_valid_i = 1; aw_ready_i = 1;
        step(); step();
        set_idle(); isolate_req_i = 1;
        step();
        isolate_req_i = 0;
        step();
        ar_valid_i = 1;
        #1 chk("undrain_ar_pass", 32'(ar_valid_o), 1);
        step();
        set_idle(); isolate_req_i = 1;
        step();
        rst_i = 1;
        step();
        rst_i = 0; isolate_req_i = 0;
        #1 chk("rst_mid_wr", 32'(wr_outstanding_o), 0);
        chk("rst_mid_err", 32'(err_o), 0);
        aw_valid_i = 1;
        #1 chk("rst_mid_run", 32'(aw_valid_o), 1);
        step();

        repeat (120) begin rand_inputs($urandom_range(0, 3) == 0); step(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
